// File: rtl/rx_module.sv
// UART 8N1 receiver: synchronizes the serial line, samples each bit near its centre,
// and reports every byte with a one-cycle done pulse or a one-cycle framing-error pulse.
module rx_module #(
  parameter int unsigned CLK_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Rx_Pin_In,
  input  logic       Rx_En_Sig,
  output logic [7:0] Rx_Data,
  output logic       Rx_Done_Sig,
  output logic       Rx_Err_Sig
);

  localparam logic [15:0] LP_HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0] LP_FULL_M1 = 16'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_timer;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_done;
  logic        r_err;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic [1:0]  r_warm;

  logic        w_line;
  logic        w_fall;
  logic        w_timer_half;
  logic        w_timer_full;
  logic        w_sample_data;
  logic        w_done_nxt;
  logic        w_err_nxt;

  // NOTE: the synchronizer resets to 1 (idle line level) so a reset never fakes a start edge
  // by itself; the warm-up counter additionally keeps edge detection off until r_sync3
  // holds a real line sample, so a line already low at reset release is not a start.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
      r_warm  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, which is
      // what turns these three statements into a shift chain rather than one wire.
      r_sync1 <= Rx_Pin_In;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  assign w_line       = r_sync2;
  assign w_fall       = (r_warm == 2'd3) && r_sync3 && !r_sync2;
  assign w_timer_half = (r_timer == LP_HALF_M1);
  assign w_timer_full = (r_timer == LP_FULL_M1);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaulting to the current state before the case keeps this block latch-free.
    w_state_nxt = r_state;
    if (!Rx_En_Sig) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:      if (w_fall) w_state_nxt = S_START;
        S_START:     if (w_timer_half) w_state_nxt = w_line ? S_IDLE : S_DATA;
        S_DATA:      if (w_timer_full && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
        S_STOP:      if (w_timer_full) w_state_nxt = w_line ? S_IDLE : S_WAIT_HIGH;
        S_WAIT_HIGH: if (w_line) w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sample_data = Rx_En_Sig && (r_state == S_DATA) && w_timer_full;
    w_done_nxt    = Rx_En_Sig && (r_state == S_STOP) && w_timer_full && w_line;
    w_err_nxt     = Rx_En_Sig && (r_state == S_STOP) && w_timer_full && !w_line;
  end

  // Timer restarts on every state change and at each data-bit boundary; it saturates
  // rather than wrapping while parked in IDLE or WAIT_HIGH.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_timer <= 16'd0;
    end else if ((w_state_nxt != r_state) || w_sample_data) begin
      r_timer <= 16'd0;
    end else if (r_timer != 16'hFFFF) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else if (r_state != S_DATA && w_state_nxt != S_STOP && r_state != S_STOP) begin
      r_bit_idx <= 3'd0;
      if (r_state == S_IDLE) r_shift <= 8'h00;
    end else if (w_sample_data) begin
      r_bit_idx <= r_bit_idx + 3'd1;
      r_shift   <= {w_line, r_shift[7:1]};
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_rx_data <= 8'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_done_nxt) r_rx_data <= r_shift;
    end
  end

  assign Rx_Data     = r_rx_data;
  assign Rx_Done_Sig = r_done;
  assign Rx_Err_Sig  = r_err;

endmodule

// File: tb/tb_rx_module.sv
// Randomized scoreboard bench for rx_module: a serial-line driver pushes the expected
// outcome of each frame, and an independent monitor pops and compares on every pulse.
module tb_rx_module;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic       rx_en  = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_err;

  always #5 clk = ~clk;

  rx_module #(.CLK_PER_BIT(CPB)) dut (
    .CLK         (clk),
    .RST_n       (rst_n),
    .Rx_Pin_In   (rx_pin),
    .Rx_En_Sig   (rx_en),
    .Rx_Data     (rx_data),
    .Rx_Done_Sig (rx_done),
    .Rx_Err_Sig  (rx_err)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard; between pulses the
  // output byte must hold the value the model last delivered.
  logic [7:0] exp_hold   = 8'h00;
  logic       prev_pulse = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_hold   = 8'h00;
      prev_pulse = 1'b0;
    end else begin
      if (rx_done || rx_err) begin
        check("pulse_exclusive", 32'(rx_done & rx_err), 32'd0);
        check("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, rx_done, rx_err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_is_err", 32'(rx_err), 32'(e.is_err));
          check("rx_data_on_pulse", 32'(rx_data), 32'(e.data));
          exp_hold = e.data;
        end
      end else begin
        check("rx_data_stable", 32'(rx_data), 32'(exp_hold));
      end
      prev_pulse = rx_done | rx_err;
    end
  end

  // Drives one frame. drop_bit >= 0 removes enable for the second half of that bit;
  // rst_bit >= 0 resets the DUT in the middle of that bit and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int drop_bit, input int rst_bit);
    bit dropped = 1'b0;
    if (drop_bit < 0 && rst_bit < 0) begin
      if (stop_bit) begin
        sb_q.push_back('{is_err: 1'b0, data: data});
        last_good = data;
      end else begin
        sb_q.push_back('{is_err: 1'b1, data: last_good});
      end
    end
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_pin = data[i];
      if (dropped) rx_en = 1'b1;
      if (i == rst_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_done", 32'(rx_done), 32'd0);
        check("reset_err", 32'(rx_err), 32'd0);
        last_good = 8'h00;
        rx_pin = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        return;
      end
      if (i == drop_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #1 rx_en = 1'b0;
        dropped = 1'b1;
        repeat (CPB - CPB / 2) @(posedge clk);
      end else begin
        repeat (CPB) @(posedge clk);
      end
    end
    #1 rx_pin = stop_bit;
    rx_en = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic hold_low_then_idle(input int low_cycles);
    repeat (low_cycles) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic glitch(input int width);
    @(posedge clk); #1 rx_pin = 1'b0;
    repeat (width) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       ok;

    #12;
    check("reset_state_data", 32'(rx_data), 32'd0);
    check("reset_state_done", 32'(rx_done), 32'd0);
    check("reset_state_err", 32'(rx_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; rx_en = 1'b1;
    repeat (2 * CPB) @(posedge clk);

    // Back-to-back frames with full-length stop bits.
    send_frame(8'h2E, 1'b1, -1, -1);
    send_frame(8'h3F, 1'b1, -1, -1);
    send_frame(8'hDD, 1'b1, -1, -1);
    repeat (CPB) @(posedge clk);

    // Short low glitch is rejected in START.
    glitch(4);
    send_frame(8'h55, 1'b1, -1, -1);

    // Framing error followed by a 40-cycle break yields a single error pulse.
    send_frame(8'hA5, 1'b0, -1, -1);
    hold_low_then_idle(40);
    send_frame(8'h01, 1'b1, -1, -1);

    // Enable removed during bit 4 discards the frame.
    send_frame(8'hFF, 1'b1, 4, -1);
    repeat (2 * CPB) @(posedge clk);
    send_frame(8'h80, 1'b1, -1, -1);

    // Reset in the middle of a data bit aborts silently.
    send_frame(8'h3C, 1'b1, -1, 3);
    send_frame(8'hC3, 1'b1, -1, -1);

    // A line already low at reset release is not a start bit.
    #1 rx_pin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_good = 8'h00;
    repeat (3 * CPB) @(posedge clk);
    #1 rx_pin = 1'b1;
    repeat (12 * CPB) @(posedge clk);

    // Serial-driver loopback bytes, then a randomized mix.
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    send_frame(8'h2E, 1'b1, -1, -1);
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, CPB / 2 - 3));
      send_frame(d, ok, -1, -1);
      if (!ok) hold_low_then_idle($urandom_range(0, 30));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    for (int i = 0; i < 20 * CPB && sb_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
